// File: rtl/piso_shift_tx_pkg.sv
// Shared sequencing definitions for the serial shift blocks: FSM state
// encoding and the counter-width helper.
package piso_shift_tx_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Width of a counter that indexes n items; never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/piso_shift_tx_bit_counter.sv
// Bit-position counter for a word in flight, with a registered terminal flag
// that is high while the last bit of the word is presented.
module piso_shift_tx_bit_counter
    import piso_shift_tx_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic term
);

    localparam int CW = clog2_min1(WIDTH);
    localparam logic [CW-1:0] PENULT = CW'((WIDTH > 1) ? WIDTH - 2 : 0);

    logic [CW-1:0] cnt;

    // term is precomputed one step ahead so it is a flop output, and it drops
    // when the final bit is consumed so it never flags outside a word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            term <= 1'b0;
        end else if (clr) begin
            cnt  <= '0;
            term <= (WIDTH == 1);
        end else if (inc) begin
            cnt  <= term ? '0 : cnt + 1'b1;
            term <= (WIDTH > 1) && (cnt == PENULT);
        end
    end

endmodule

// File: rtl/piso_shift_tx.sv
// Parallel-in serial-out transmitter: takes a word on valid/ready and shifts
// it out one bit per en tick with first/last framing strobes.
module piso_shift_tx
    import piso_shift_tx_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             sout_first,
    output logic             sout_last,
    output logic             busy
);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shreg;
    logic             term;
    logic             load;
    logic             step;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    // in_ready is gated by rst so nothing is offered while reset is held.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        step      = 1'b0;
        case (state)
            ST_IDLE: in_ready = rst;
            ST_SHIFT: begin
                step     = en;
                in_ready = rst & en & term;
                if (en && term && !in_valid) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        load = in_valid & in_ready;
        if (load) state_nxt = ST_SHIFT;
    end

    // Zero fill means the register is all zeros once the last bit leaves,
    // which keeps sout low whenever no word is in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg      <= '0;
            sout_first <= 1'b0;
        end else if (load) begin
            shreg      <= in_data;
            sout_first <= 1'b1;
        end else if (step) begin
            shreg      <= LSB_FIRST ? (shreg >> 1) : (shreg << 1);
            sout_first <= 1'b0;
        end
    end

    piso_shift_tx_bit_counter #(
        .WIDTH(WIDTH)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (load),
        .inc (step),
        .term(term)
    );

    assign sout       = LSB_FIRST ? shreg[0] : shreg[WIDTH-1];
    assign sout_valid = (state == ST_SHIFT);
    assign busy       = sout_valid;
    assign sout_last  = term;

endmodule

// File: tb/tb_piso_shift_tx.sv
// Directed bench for piso_shift_tx: three instances (8b LSB-first, 8b MSB-first
// with en stalls, 1b) checked bit by bit against a queue of expected bits.
module tb_piso_shift_tx;

    typedef struct packed {
        logic b;
        logic f;
        logic l;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en         [3];
    logic       in_valid   [3];
    logic [7:0] in_data    [3];
    logic       in_ready   [3];
    logic       sout       [3];
    logic       sout_valid [3];
    logic       sout_first [3];
    logic       sout_last  [3];
    logic       busy       [3];

    exp_t q[3][$];
    bit   act[3];
    int   n_cmp = 0;
    int   n_err = 0;
    int   phase = 0;

    always #5 clk = ~clk;

    piso_shift_tx #(.WIDTH(8), .LSB_FIRST(1'b1)) u_l8 (
        .clk(clk), .rst(rst), .en(en[0]), .in_valid(in_valid[0]), .in_data(in_data[0]),
        .in_ready(in_ready[0]), .sout(sout[0]), .sout_valid(sout_valid[0]),
        .sout_first(sout_first[0]), .sout_last(sout_last[0]), .busy(busy[0])
    );

    piso_shift_tx #(.WIDTH(8), .LSB_FIRST(1'b0)) u_m8 (
        .clk(clk), .rst(rst), .en(en[1]), .in_valid(in_valid[1]), .in_data(in_data[1]),
        .in_ready(in_ready[1]), .sout(sout[1]), .sout_valid(sout_valid[1]),
        .sout_first(sout_first[1]), .sout_last(sout_last[1]), .busy(busy[1])
    );

    piso_shift_tx #(.WIDTH(1), .LSB_FIRST(1'b1)) u_w1 (
        .clk(clk), .rst(rst), .en(en[2]), .in_valid(in_valid[2]), .in_data(in_data[2][0:0]),
        .in_ready(in_ready[2]), .sout(sout[2]), .sout_valid(sout_valid[2]),
        .sout_first(sout_first[2]), .sout_last(sout_last[2]), .busy(busy[2])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // en pacing: instances 0 and 2 tick every cycle, instance 1 every third cycle.
    always @(posedge clk) begin
        #1;
        phase = (phase == 2) ? 0 : phase + 1;
        en[0] = 1'b1;
        en[1] = (phase == 2);
        en[2] = 1'b1;
    end

    // Reference model: tracks word-in-flight, predicts in_ready, and compares
    // the presented bit and strobes; a bit is consumed on an en edge.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            bit   rdy;
            bit   has;
            exp_t e;
            if (!rst) act[k] = 1'b0;
            has = (q[k].size() != 0);
            e   = has ? q[k][0] : '0;
            rdy = rst && (!act[k] || (en[k] && has && e.l));
            chk($sformatf("valid%0d", k), sout_valid[k], act[k]);
            chk($sformatf("busy%0d", k), busy[k], act[k]);
            chk($sformatf("ready%0d", k), in_ready[k], rdy);
            if (act[k] && has) begin
                chk($sformatf("sout%0d", k), sout[k], e.b);
                chk($sformatf("first%0d", k), sout_first[k], e.f);
                chk($sformatf("last%0d", k), sout_last[k], e.l);
            end else if (!act[k]) begin
                chk($sformatf("sout_idle%0d", k), sout[k], 1'b0);
                chk($sformatf("first_idle%0d", k), sout_first[k], 1'b0);
                chk($sformatf("last_idle%0d", k), sout_last[k], 1'b0);
            end
            if (act[k] && en[k] && has) begin
                void'(q[k].pop_front());
                if (e.l) act[k] = 1'b0;
            end
            if (in_valid[k] && rdy) act[k] = 1'b1;
        end
    end

    task automatic send(input int k, input logic [7:0] d);
        int w;
        bit lsb;
        bit done;
        w = (k == 2) ? 1 : 8;
        lsb = (k != 1);
        for (int i = 0; i < w; i++) begin
            exp_t e;
            e.b = lsb ? d[i] : d[w-1-i];
            e.f = (i == 0);
            e.l = (i == w - 1);
            q[k].push_back(e);
        end
        in_valid[k] = 1'b1;
        in_data[k]  = d;
        done = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            done = in_ready[k] & in_valid[k];
            @(posedge clk);
            #1;
        end
        if (!done) chk($sformatf("send_timeout%0d", k), done, 1'b1);
        in_valid[k] = 1'b0;
    endtask

    task automatic drain(input int k);
        bit done;
        done = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            #1;
            done = (q[k].size() == 0) && !sout_valid[k];
        end
        chk($sformatf("drain%0d", k), done, 1'b1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            in_valid[k] = 1'b1;
            in_data[k]  = 8'h00;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_ready%0d", k), in_ready[k], 1'b0);
            chk($sformatf("rst_valid%0d", k), sout_valid[k], 1'b0);
            chk($sformatf("rst_sout%0d", k), sout[k], 1'b0);
        end
        rst = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rel_ready%0d", k), in_ready[k], 1'b1);
            in_valid[k] = 1'b0;
        end

        send(0, 8'hA5);
        drain(0);

        send(1, 8'hC3);
        drain(1);

        send(0, 8'h01);
        send(0, 8'h80);
        drain(0);

        send(0, 8'hFF);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        q[0].delete();
        #1;
        chk("abort_valid", sout_valid[0], 1'b0);
        chk("abort_sout", sout[0], 1'b0);
        chk("abort_last", sout_last[0], 1'b0);
        chk("abort_busy", busy[0], 1'b0);
        chk("abort_ready", in_ready[0], 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        send(0, 8'h3C);
        drain(0);

        send(2, 8'h01);
        send(2, 8'h00);
        send(2, 8'h01);
        drain(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
